// File: rtl/keypad_pkg.sv
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types, key map and helper function for the 4x4
//                keypad scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

   // Scanner FSM states
   typedef enum logic [1:0] {
      SCAN = 2'd0,
      DEB  = 2'd1,
      HELD = 2'd2
   } state_t;

   // Row / column index
   typedef logic [1:0] idx_t;

   // Hex code per key, indexed [row][col]; row 0 is the top row of the pad
   localparam logic [0:3][0:3][3:0] KEY_MAP = {16'h123A, 16'h456B, 16'h789C, 16'hE0FD};

   // Index of the set bit in a one-hot nibble (0 for anything not one-hot)
   function automatic idx_t onehot2idx(input logic [3:0] v);
      idx_t idx;
      case (v)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_sync.sv
// ============================================================================
//  Module      : keypad_sync
//  Description : Parameterized-width 2-flop synchronizer, async active-high
//                reset to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_meta;

   // Two back-to-back flops to settle metastability on the async inputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= '0;
         q      <= '0;
      end else begin
         r_meta <= d;
         q      <= r_meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner. Drives one-hot columns,
//                synchronizes and debounces the rows, and emits one hex key
//                code with a single-cycle strobe per press.
//                Optional macro KEYPAD_AUTOREPEAT_EN enables auto-repeat
//                strobes while a key stays held.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV    = 8,
   parameter int DEBOUNCE    = 4,
   parameter int REPEAT_DLY  = 16,
   parameter int REPEAT_RATE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] r,
   output logic [3:0] c,
   output logic [3:0] key,
   output logic       key_valid
);

   localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int c_cnt_w = $clog2(DEBOUNCE + 1);

   // Parameter sanity: the dwell must outlast the synchronizer latency
   if (SCAN_DIV < 4) begin : g_chk_scan_div
      $error("keypad_scanner: SCAN_DIV must be >= 4");
   end
   if (DEBOUNCE < 2) begin : g_chk_debounce
      $error("keypad_scanner: DEBOUNCE must be >= 2");
   end
   if (REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_chk_repeat
      $error("keypad_scanner: REPEAT_DLY and REPEAT_RATE must be >= 1");
   end

   logic [3:0]         w_rs;
   logic               w_tick;
   logic               w_rs_single;
   logic [3:0]         w_row_oh;
   logic [3:0]         w_c_next;

   state_t             r_state;
   logic [c_div_w-1:0] r_div_cnt;
   logic [c_cnt_w-1:0] r_match_cnt;
   logic [c_cnt_w-1:0] r_rel_cnt;
   idx_t               r_row;
   idx_t               r_col;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int c_rep_w = $clog2(((REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE) + 1);
   logic [c_rep_w-1:0] r_rep_cnt;
   logic               r_rep_first;
`else
   // Single strobe per press: no repeat state is kept
`endif

   keypad_sync #(
      .WIDTH (4)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (r),
      .q     (w_rs)
   );

   // Sample tick, row qualification and next column in rotation
   always_comb begin
      w_tick      = (r_div_cnt == c_div_w'(SCAN_DIV - 1));
      w_rs_single = (w_rs != 4'b0000) && ((w_rs & (w_rs - 4'b0001)) == 4'b0000);
      w_row_oh    = 4'b0001 << r_row;
      w_c_next    = {c[2:0], c[3]};
   end

   // Scanner FSM: dwell counter, column drive, debounce and key output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= SCAN;
         r_div_cnt   <= '0;
         r_match_cnt <= '0;
         r_rel_cnt   <= '0;
         r_row       <= '0;
         r_col       <= '0;
         c           <= 4'b0001;
         key         <= 4'h0;
         key_valid   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b1;
`endif
      end else begin
         key_valid <= 1'b0;
         r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;

         if (w_tick) begin
            case (r_state)
               SCAN: begin
                  // Only a single active row is a candidate press
                  if (w_rs_single) begin
                     r_row       <= onehot2idx(w_rs);
                     r_col       <= onehot2idx(c);
                     r_match_cnt <= c_cnt_w'(1);
                     r_state     <= DEB;
                  end else begin
                     c <= w_c_next;
                  end
               end

               DEB: begin
                  if (w_rs == w_row_oh) begin
                     if (r_match_cnt == c_cnt_w'(DEBOUNCE - 1)) begin
                        key         <= KEY_MAP[r_row][r_col];
                        key_valid   <= 1'b1;
                        r_rel_cnt   <= '0;
                        r_state     <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        r_rep_cnt   <= '0;
                        r_rep_first <= 1'b1;
`endif
                     end else begin
                        r_match_cnt <= r_match_cnt + 1'b1;
                     end
                  end else begin
                     // Unstable sample: treat as a glitch and keep scanning
                     r_state <= SCAN;
                     c       <= w_c_next;
                  end
               end

               HELD: begin
                  // Release needs DEBOUNCE consecutive all-clear samples
                  if (w_rs == 4'b0000) begin
                     if (r_rel_cnt == c_cnt_w'(DEBOUNCE - 1)) begin
                        r_rel_cnt <= '0;
                        r_state   <= SCAN;
                        c         <= w_c_next;
                     end else begin
                        r_rel_cnt <= r_rel_cnt + 1'b1;
                     end
                  end else begin
                     r_rel_cnt <= '0;
                  end
`ifdef KEYPAD_AUTOREPEAT_EN
                  // Repeat the held key: long first delay, then a steady rate
                  if (w_rs == w_row_oh) begin
                     if (r_rep_cnt == (r_rep_first ? c_rep_w'(REPEAT_DLY - 1)
                                                   : c_rep_w'(REPEAT_RATE - 1))) begin
                        key_valid   <= 1'b1;
                        r_rep_cnt   <= '0;
                        r_rep_first <= 1'b0;
                     end else begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                     end
                  end else begin
                     r_rep_cnt <= '0;
                  end
`endif
               end

               default: begin
                  r_state <= SCAN;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Directed self-checking bench for keypad_scanner
//                (SCAN_DIV=8, DEBOUNCE=4). Keypad model:
//                r = (c == cdes) ? rdes : 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

   logic       clk;
   logic       reset;
   logic [3:0] r;
   logic [3:0] c;
   logic [3:0] key;
   logic       key_valid;

   logic [3:0] rdes;
   logic [3:0] cdes;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_strobe = 0;
   int         cyc = 0;
   int         cp;
   int         stamps[$];
   logic [3:0] codes[$];

   logic [3:0] exp_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int c_t2_strobes = 3;
`else
   localparam int c_t2_strobes = 1;
`endif

   keypad_scanner #(
      .SCAN_DIV    (8),
      .DEBOUNCE    (4),
      .REPEAT_DLY  (16),
      .REPEAT_RATE (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .r         (r),
      .c         (c),
      .key       (key),
      .key_valid (key_valid)
   );

   assign r = (c == cdes) ? rdes : 4'b0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle stamp
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (!reset && key_valid) begin
         n_strobe = n_strobe + 1;
         codes.push_back(key);
         stamps.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      n_strobe = 0;
      codes.delete();
      stamps.delete();
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Wait (bounded) for a given column drive value
   task automatic wait_col(input logic [3:0] v);
      int n = 0;
      while (c !== v && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("wait_col", {28'd0, c}, {28'd0, v});
   endtask

   initial begin
      reset = 1'b1;
      rdes  = 4'b0000;
      cdes  = 4'b0000;

      // 1: reset values, then column rotation every 8 cycles
      cycles(50);
      check("rst_c", {28'd0, c}, 32'h1);
      check("rst_key", {28'd0, key}, 32'h0);
      check("rst_kv", {31'd0, key_valid}, 32'h0);
      reset = 1'b0;
      cycles(7);
      check("rot_c0", {28'd0, c}, 32'h1);
      cycles(1);
      check("rot_c1", {28'd0, c}, 32'h2);
      cycles(8);
      check("rot_c2", {28'd0, c}, 32'h4);

      // 2: key '5' (row1,col1): one strobe, fixed latency, column frozen
      wait_col(4'b0100);
      clear_log();
      rdes = 4'b0010;
      cdes = 4'b0010;
      wait_col(4'b0010);
      cp = cyc;
      cycles(200);
      check("t2_strobes", n_strobe, c_t2_strobes);
      check("t2_key", {28'd0, key}, 32'h5);
      check("t2_lat", (stamps.size() > 0) ? stamps[0] - cp : -1, 32);
      check("t2_c_held", {28'd0, c}, 32'h2);
      rdes = 4'b0000;
      cycles(20);
      check("t2_c_rel20", {28'd0, c}, 32'h2);
      cycles(20);
      check("t2_c_rel40", {31'd0, (c != 4'b0010)}, 32'h1);
      cycles(100);

      // 3: sweep all 16 keys in row-major order
      clear_log();
      for (int row = 0; row < 4; row++) begin
         for (int col = 0; col < 4; col++) begin
            rdes = 4'b0001 << row;
            cdes = 4'b0001 << col;
            cycles(120);
            rdes = 4'b0000;
            cycles(200);
         end
      end
      check("t3_strobes", n_strobe, 16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t3_code%0d", i),
               (i < codes.size()) ? {28'd0, codes[i]} : 32'hFF, {28'd0, exp_tab[i]});
      end

      // 4a: bouncing row, then stable -> one strobe of '7'
      clear_log();
      cdes = 4'b0001;
      for (int k = 0; k < 12; k++) begin
         rdes = (k % 2 == 0) ? 4'b0100 : 4'b0000;
         cycles(5);
      end
      rdes = 4'b0100;
      cycles(120);
      rdes = 4'b0000;
      cycles(200);
      check("t4_strobes", n_strobe, 1);
      check("t4_key", {28'd0, key}, 32'h7);

      // 4b: 3-cycle pulse landing on a sample tick -> rejected
      clear_log();
      wait_col(4'b1000);
      wait_col(4'b0001);
      cycles(4);
      rdes = 4'b0100;
      cycles(3);
      rdes = 4'b0000;
      cycles(100);
      check("t4_pulse", n_strobe, 0);

      // 5: two rows in one column -> ignored, columns keep rotating
      clear_log();
      cdes = 4'b0001;
      rdes = 4'b0011;
      wait_col(4'b1000);
      wait_col(4'b0001);
      cycles(8);
      check("t5_c1", {28'd0, c}, 32'h2);
      cycles(8);
      check("t5_c2", {28'd0, c}, 32'h4);
      cycles(150);
      check("t5_strobes", n_strobe, 0);
      rdes = 4'b0000;
      cycles(50);

      // 6: reset while HELD, then press 'A'
      clear_log();
      rdes = 4'b0100;
      cdes = 4'b0100;
      cycles(120);
      check("t6_key9", {28'd0, key}, 32'h9);
      reset = 1'b1;
      cycles(2);
      check("t6_rst_c", {28'd0, c}, 32'h1);
      check("t6_rst_key", {28'd0, key}, 32'h0);
      check("t6_rst_kv", {31'd0, key_valid}, 32'h0);
      rdes = 4'b0000;
      cycles(3);
      reset = 1'b0;
      cycles(50);
      check("t6_no_strobe", n_strobe, 1);
      rdes = 4'b0001;
      cdes = 4'b1000;
      cycles(120);
      rdes = 4'b0000;
      cycles(200);
      check("t6_strobes", n_strobe, 2);
      check("t6_keyA", {28'd0, key}, 32'hA);

`ifdef KEYPAD_AUTOREPEAT_EN
      // 7: hold '7' -> first strobe, repeat after 128, then every 32
      clear_log();
      rdes = 4'b0100;
      cdes = 4'b0001;
      cycles(1000);
      rdes = 4'b0000;
      check("t7_code", (codes.size() > 0) ? {28'd0, codes[0]} : 32'hFF, 32'h7);
      check("t7_first_rep", (stamps.size() > 1) ? stamps[1] - stamps[0] : -1, 128);
      check("t7_rate1", (stamps.size() > 2) ? stamps[2] - stamps[1] : -1, 32);
      check("t7_rate2", (stamps.size() > 3) ? stamps[3] - stamps[2] : -1, 32);
      cycles(200);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
